pos_word_writer: RTL

//  Frame-rate game-state engine. Owns the two display position words that the VGA top reads from

---
 rtl/pos_pkg.sv | 21 ++
 rtl/pos_physics.sv | 50 +++++
 rtl/pos_word_writer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pos_pkg.sv
// rtl/pos_pkg.sv - shared position-RAM address map and writer FSM encoding
package pos_pkg;

    localparam logic [15:0] POS_BASE = 16'h0100;
    localparam logic [15:0] SCREEN_W = 16'd640;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] UPDATE = 3'd1;
    localparam logic [2:0] REQ    = 3'd2;
    localparam logic [2:0] WR_OBS = 3'd3;
    localparam logic [2:0] WR_PLY = 3'd4;

    function automatic logic owns_port(input logic [2:0] st);
        return (st == REQ) || (st == WR_OBS) || (st == WR_PLY);
    endfunction

    function automatic logic is_write(input logic [2:0] st);
        return (st == WR_OBS) || (st == WR_PLY);
    endfunction

endpackage

// File: rtl/pos_physics.sv
// rtl/pos_physics.sv - combinational per-frame obstacle scroll and player jump physics
module pos_physics
    import pos_pkg::*;
#(
    parameter logic [15:0] X_WRAP      = SCREEN_W,
    parameter logic [15:0] SCROLL_STEP = 16'd4,
    parameter logic [15:0] GROUND_Y    = 16'd200,
    parameter logic [7:0]  JUMP_V      = 8'd12,
    parameter logic [7:0]  GRAVITY     = 8'd1
) (
    input  logic [15:0]       obstacle_x,
    input  logic [15:0]       player_y,
    input  logic signed [8:0] vel,
    input  logic              jump_pend,
    output logic [15:0]       obstacle_x_nxt,
    output logic [15:0]       player_y_nxt,
    output logic signed [8:0] vel_nxt
);

    logic              on_ground;
    logic signed [8:0] v_launch;
    logic signed [8:0] v_grav;
    logic signed [17:0] ny;

    always_comb begin
        if (obstacle_x < SCROLL_STEP) begin
            obstacle_x_nxt = X_WRAP;
        end else begin
            obstacle_x_nxt = obstacle_x - SCROLL_STEP;
        end

        // A jump request only launches from rest; while airborne it is simply ignored.
        on_ground = (player_y == GROUND_Y) && (vel == 9'sd0);
        v_launch  = (on_ground && jump_pend) ? -$signed({1'b0, JUMP_V}) : vel;
        v_grav    = v_launch + $signed({1'b0, GRAVITY});
        ny        = $signed({2'b00, player_y}) + $signed({{9{v_launch[8]}}, v_launch});

        if (ny[17]) begin
            player_y_nxt = 16'd0;
            vel_nxt      = v_grav;
        end else if (ny >= $signed({2'b00, GROUND_Y})) begin
            player_y_nxt = GROUND_Y;
            vel_nxt      = 9'sd0;
        end else begin
            player_y_nxt = ny[15:0];
            vel_nxt      = v_grav;
        end
    end

endmodule

// File: rtl/pos_word_writer.sv
// rtl/pos_word_writer.sv - frame-rate game-state engine writing obstacle_x/player_y to position RAM
module pos_word_writer
    import pos_pkg::*;
#(
    parameter logic [15:0] X_RESET     = 16'd400,
    parameter logic [15:0] X_WRAP      = SCREEN_W,
    parameter logic [15:0] SCROLL_STEP = 16'd4,
    parameter logic [15:0] GROUND_Y    = 16'd200,
    parameter logic [7:0]  JUMP_V      = 8'd12,
    parameter logic [7:0]  GRAVITY     = 8'd1
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        jump_btn,
    input  logic        ram_gnt,
    output logic        ram_req,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_d,
    output logic [15:0] obstacle_x,
    output logic [15:0] player_y,
    output logic        busy,
    output logic        overrun
);

    logic [2:0]        state_q, state_d;
    logic [15:0]       obs_q, obs_d;
    logic [15:0]       ply_q, ply_d;
    logic signed [8:0] vel_q, vel_d;
    logic              pend_q, pend_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              ovr_q, ovr_d;

    logic [15:0]       obs_nxt;
    logic [15:0]       ply_nxt;
    logic signed [8:0] vel_nxt;

    pos_physics #(
        .X_WRAP      (X_WRAP),
        .SCROLL_STEP (SCROLL_STEP),
        .GROUND_Y    (GROUND_Y),
        .JUMP_V      (JUMP_V),
        .GRAVITY     (GRAVITY)
    ) u_physics (
        .obstacle_x     (obs_q),
        .player_y       (ply_q),
        .vel            (vel_q),
        .jump_pend      (pend_q),
        .obstacle_x_nxt (obs_nxt),
        .player_y_nxt   (ply_nxt),
        .vel_nxt        (vel_nxt)
    );

    always_comb begin
        state_d = state_q;
        obs_d   = obs_q;
        ply_d   = ply_q;
        vel_d   = vel_q;
        pend_d  = pend_q | jump_btn;
        ovr_d   = ovr_q | (frame_tick && (state_q != IDLE));
        addr_d  = addr_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (frame_tick) state_d = UPDATE;
            end
            UPDATE: begin
                obs_d   = obs_nxt;
                ply_d   = ply_nxt;
                vel_d   = vel_nxt;
                pend_d  = jump_btn;
                state_d = REQ;
            end
            REQ: begin
                if (ram_gnt) state_d = WR_OBS;
            end
            WR_OBS:  state_d = WR_PLY;
            WR_PLY:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Port outputs are registered from the next state so they align with the state itself.
        req_d = owns_port(state_d);
        we_d  = is_write(state_d);
        if (state_d == WR_OBS) begin
            addr_d = POS_BASE;
            data_d = obs_q;
        end else if (state_d == WR_PLY) begin
            addr_d = POS_BASE + 16'd1;
            data_d = ply_q;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            obs_q   <= X_RESET;
            ply_q   <= GROUND_Y;
            vel_q   <= 9'sd0;
            pend_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 16'd0;
            data_q  <= 16'd0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            obs_q   <= obs_d;
            ply_q   <= ply_d;
            vel_q   <= vel_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign ram_req    = req_q;
    assign ram_we     = we_q;
    assign ram_addr   = addr_q;
    assign ram_d      = data_q;
    assign obstacle_x = obs_q;
    assign player_y   = ply_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = ovr_q;

endmodule
